// File: rtl/beta_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// beta_mem_access_ctrl
//
// Load/store access controller for the BETA data path. Sits directly in front
// of the synchronous data memory. It takes byte-addressed LD/ST requests over a
// valid/ready handshake, rejects misaligned or out-of-range addresses, and
// drives a word index, write data and a one-cycle write strobe into the memory.
// Load data is captured from the memory's registered read port. Exactly one
// response is returned per accepted request. A sticky fault record and
// saturating load/store counters are kept for software.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_we, req_addr, req_wdata  store flag, byte address, store data
//   resp_valid/resp_ready      response handshake (valid held until ready)
//   resp_rdata, resp_err       load data (0 for store/error), fault flag
//   mem_adr, mem_wd, mem_wr    word index, write data, write enable to memory
//   mem_rd                     memory read data, one cycle after mem_adr
//   clear_fault                clears fault_flag/fault_addr
//   fault_flag, fault_addr     sticky fault indication and last faulting addr
//   ld_cnt, st_cnt             saturating counts of completed loads/stores
// ---------------------------------------------------------------------------
module beta_mem_access_ctrl #(
    parameter int MEM_WORDS = 1024,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic             resp_err,
    output logic [31:0]      mem_adr,
    output logic [31:0]      mem_wd,
    output logic             mem_wr,
    input  logic [31:0]      mem_rd,
    input  logic             clear_fault,
    output logic             fault_flag,
    output logic [31:0]      fault_addr,
    output logic [CNT_W-1:0] ld_cnt,
    output logic [CNT_W-1:0] st_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [31:0]      MEM_WORDS_W = 32'(MEM_WORDS);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t state;
    state_t state_next;
    logic   we_q;
    logic   accept;
    logic   fault;

    assign accept = (state == IDLE) && req_valid;

    // The index is compared at full 32-bit width so that high addresses such
    // as 0xFFFFFFFC are rejected rather than aliasing into low memory.
    assign fault = (req_addr[1:0] != 2'b00) ||
                   ({2'b00, req_addr[31:2]} >= MEM_WORDS_W);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: the default assignment up front guarantees every path assigns
    // state_next, so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (req_valid) state_next = fault ? RESP : ACCESS;
            ACCESS:  state_next = we_q ? RESP : CAPTURE;
            CAPTURE: state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_wr     = 1'b0;
        unique case (state)
            IDLE:    req_ready  = 1'b1;
            ACCESS:  mem_wr     = we_q;
            CAPTURE: ;
            RESP:    resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Request capture, response data, fault record and counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            mem_adr    <= '0;
            mem_wd     <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            fault_flag <= 1'b0;
            fault_addr <= '0;
            ld_cnt     <= '0;
            st_cnt     <= '0;
        end else begin
            // clear_fault is applied first so that a fault accepted in the
            // same cycle overrides it.
            if (clear_fault) begin
                fault_flag <= 1'b0;
                fault_addr <= '0;
            end

            if (accept) begin
                we_q       <= req_we;
                mem_adr    <= {2'b00, req_addr[31:2]};
                mem_wd     <= req_wdata;
                resp_rdata <= '0;
                resp_err   <= fault;
                if (fault) begin
                    fault_flag <= 1'b1;
                    fault_addr <= req_addr;
                end
            end

            if (state == ACCESS && we_q && st_cnt != CNT_MAX) begin
                st_cnt <= st_cnt + 1'b1;
            end

            if (state == CAPTURE) begin
                resp_rdata <= mem_rd;
                if (ld_cnt != CNT_MAX) begin
                    ld_cnt <= ld_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_beta_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_beta_mem_access_ctrl
//
// Directed bench for beta_mem_access_ctrl with MEM_WORDS=1024 and CNT_W=2 so
// counter saturation is reachable. A small synchronous memory with a
// registered read port stands in for MEM_DATA. Inputs change 1 time unit after
// the rising edge, outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_beta_mem_access_ctrl;

    localparam int MEM_WORDS = 1024;
    localparam int CNT_W     = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_rdata;
    logic             resp_err;
    logic [31:0]      mem_adr;
    logic [31:0]      mem_wd;
    logic             mem_wr;
    logic [31:0]      mem_rd;
    logic             clear_fault;
    logic             fault_flag;
    logic [31:0]      fault_addr;
    logic [CNT_W-1:0] ld_cnt;
    logic [CNT_W-1:0] st_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    beta_mem_access_ctrl #(
        .MEM_WORDS(MEM_WORDS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_adr    (mem_adr),
        .mem_wd     (mem_wd),
        .mem_wr     (mem_wr),
        .mem_rd     (mem_rd),
        .clear_fault(clear_fault),
        .fault_flag (fault_flag),
        .fault_addr (fault_addr),
        .ld_cnt     (ld_cnt),
        .st_cnt     (st_cnt)
    );

    // Data memory stand-in: word i preloaded with 0xA5000000 | i.
    logic [31:0] tb_mem [MEM_WORDS];
    initial begin
        for (int i = 0; i < MEM_WORDS; i++) tb_mem[i] = 32'hA500_0000 | 32'(i);
    end
    always @(posedge clk) begin
        if (mem_wr) tb_mem[mem_adr[9:0]] <= mem_wd;
        mem_rd <= tb_mem[mem_adr[9:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request in the current cycle (cycle 0) and follows it until
    // resp_valid rises or a cycle budget runs out. lat is the cycle number in
    // which resp_valid was first seen.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output int wr_cycles, output logic [31:0] wr_adr);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        step();
        req_valid = 1'b0;
        lat       = 1;
        wr_cycles = 0;
        wr_adr    = 32'hFFFF_FFFF;
        while (!resp_valid && lat < 10) begin
            if (mem_wr) begin
                wr_cycles++;
                wr_adr = mem_adr;
            end
            step();
            lat++;
        end
    endtask

    task automatic take_resp();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    int          lat;
    int          wrc;
    logic [31:0] wra;
    logic [31:0] snap;
    logic        stable;
    logic        seen;

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        resp_ready  = 1'b0;
        clear_fault = 1'b0;
        step();
        step();

        // Reset state
        check("rst_req_ready",  32'(req_ready),  32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_wr",     32'(mem_wr),     32'd0);
        check("rst_mem_adr",    mem_adr,         32'd0);
        check("rst_fault_flag", 32'(fault_flag), 32'd0);
        check("rst_cnts",       32'({ld_cnt, st_cnt}), 32'd0);
        rst_n = 1'b1;
        step();

        // T1: store 0xDEADBEEF to 0x10, then load it back
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, lat, wrc, wra);
        check("t1_st_lat",     32'(lat), 32'd2);
        check("t1_st_wr_cnt",  32'(wrc), 32'd1);
        check("t1_st_wr_adr",  wra,      32'd4);
        check("t1_st_rdata",   resp_rdata, 32'd0);
        check("t1_st_err",     32'(resp_err), 32'd0);
        check("t1_st_cnt",     32'(st_cnt), 32'd1);
        take_resp();
        check("t1_resp_drop",  32'(resp_valid), 32'd0);
        check("t1_ready_back", 32'(req_ready),  32'd1);
        issue(1'b0, 32'h10, 32'h0, lat, wrc, wra);
        check("t1_ld_lat",     32'(lat), 32'd3);
        check("t1_ld_wr_cnt",  32'(wrc), 32'd0);
        check("t1_ld_rdata",   resp_rdata, 32'hDEAD_BEEF);
        check("t1_ld_err",     32'(resp_err), 32'd0);
        check("t1_ld_cnt",     32'(ld_cnt), 32'd1);
        take_resp();

        // T2: misaligned load
        issue(1'b0, 32'h13, 32'h0, lat, wrc, wra);
        check("t2_lat",        32'(lat), 32'd1);
        check("t2_err",        32'(resp_err), 32'd1);
        check("t2_rdata",      resp_rdata, 32'd0);
        check("t2_wr_cnt",     32'(wrc), 32'd0);
        check("t2_fault_flag", 32'(fault_flag), 32'd1);
        check("t2_fault_addr", fault_addr, 32'h13);
        check("t2_ld_cnt",     32'(ld_cnt), 32'd1);
        take_resp();

        // T3: first out-of-range index, then last valid index
        issue(1'b0, 32'h1000, 32'h0, lat, wrc, wra);
        check("t3_oor_lat",    32'(lat), 32'd1);
        check("t3_oor_err",    32'(resp_err), 32'd1);
        check("t3_oor_faddr",  fault_addr, 32'h1000);
        take_resp();
        issue(1'b0, 32'hFFC, 32'h0, lat, wrc, wra);
        check("t3_last_lat",   32'(lat), 32'd3);
        check("t3_last_err",   32'(resp_err), 32'd0);
        check("t3_last_rdata", resp_rdata, 32'hA500_03FF);
        check("t3_ld_cnt",     32'(ld_cnt), 32'd2);
        take_resp();

        // T4: response back-pressure for 5 cycles with a competing request
        issue(1'b0, 32'h20, 32'h0, lat, wrc, wra);
        check("t4_lat",   32'(lat), 32'd3);
        check("t4_rdata", resp_rdata, 32'hA500_0008);
        snap      = resp_rdata;
        stable    = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h40;
        req_wdata = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            step();
            if (!(resp_valid && resp_rdata == snap && !req_ready && !mem_wr && mem_adr == 32'd8))
                stable = 1'b0;
        end
        req_valid = 1'b0;
        check("t4_stable",  32'(stable), 32'd1);
        check("t4_ld_sat",  32'(ld_cnt), 32'd3);
        take_resp();
        check("t4_released", 32'(resp_valid), 32'd0);
        check("t4_tb_mem_untouched", tb_mem[16], 32'hA500_0010);
        issue(1'b0, 32'h24, 32'h0, lat, wrc, wra);
        check("t4_ld_hold_sat", 32'(ld_cnt), 32'd3);
        take_resp();

        // T5: reset while a store is in ACCESS
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h30;
        req_wdata = 32'hCAFE_F00D;
        step();
        req_valid = 1'b0;
        check("t5_in_access", 32'(mem_wr), 32'd1);
        rst_n = 1'b0;
        step();
        check("t5_mem_wr",     32'(mem_wr),     32'd0);
        check("t5_resp_valid", 32'(resp_valid), 32'd0);
        check("t5_req_ready",  32'(req_ready),  32'd1);
        check("t5_cnts",       32'({ld_cnt, st_cnt}), 32'd0);
        check("t5_fault_flag", 32'(fault_flag), 32'd0);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (resp_valid) seen = 1'b1;
        end
        check("t5_no_resp", 32'(seen), 32'd0);

        // T6: store counter saturation, then fault-record priority
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 32'(i * 4), 32'(i), lat, wrc, wra);
            take_resp();
        end
        check("t6_st_sat", 32'(st_cnt), 32'd3);
        issue(1'b0, 32'h5, 32'h0, lat, wrc, wra);
        take_resp();
        check("t6_fault_set", 32'(fault_flag), 32'd1);
        clear_fault = 1'b1;
        req_valid   = 1'b1;
        req_we      = 1'b0;
        req_addr    = 32'hFFFF_FFFC;
        step();
        clear_fault = 1'b0;
        req_valid   = 1'b0;
        check("t6_wrap_resp",  32'(resp_valid), 32'd1);
        check("t6_wrap_err",   32'(resp_err),   32'd1);
        check("t6_fault_keep", 32'(fault_flag), 32'd1);
        check("t6_fault_addr", fault_addr, 32'hFFFF_FFFC);
        take_resp();
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;
        check("t6_clear_flag", 32'(fault_flag), 32'd0);
        check("t6_clear_addr", fault_addr, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
